// File: rtl/pe_sparse_agu_pkg.sv
// Shared definitions for the sparse PE address generator.
package pe_sparse_agu_pkg;

  // Default index field width; an index entry is {p_idx, d_idx}.
  localparam int unsigned IDX_W = 8;
  // Default number of accumulate lanes.
  localparam int unsigned BATCH = 4;

  // Operand role selection: FWD accumulates on p_idx, BWD on d_idx.
  typedef enum logic {
    AGU_FWD = 1'b0,
    AGU_BWD = 1'b1
  } agu_mode_e;

  // Address width needed to index n entries (never less than 1 bit).
  function automatic int unsigned bw(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pe_sparse_agu_ping_pong_ram.sv
// Two-bank index store: one bank is read while the other is written; a pulse
// on switch_buf swaps the roles. Reads are combinational.
module ping_pong_ram
  import pe_sparse_agu_pkg::*;
#(
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned ADDR_W   = bw(DEPTH),
  parameter string       RAM_TYPE = "distributed"
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              switch_buf,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic rd_bank_q;

  // Bank select toggles on each swap request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_bank_q <= 1'b0;
    end else if (switch_buf) begin
      rd_bank_q <= ~rd_bank_q;
    end
  end

  // Async read rules out block RAM, so both styles infer LUT storage.
  if (RAM_TYPE == "distributed") begin : g_dist
    (* ram_style = "distributed" *) logic [WIDTH-1:0] mem [2][DEPTH];

    // Writes always land in the bank not currently being read.
    always_ff @(posedge clk) begin
      if (wr_en) begin
        mem[~rd_bank_q][wr_addr] <= wr_data;
      end
    end

    assign rd_data = mem[rd_bank_q][rd_addr];
  end else begin : g_auto
    logic [WIDTH-1:0] mem [2][DEPTH];

    // Writes always land in the bank not currently being read.
    always_ff @(posedge clk) begin
      if (wr_en) begin
        mem[~rd_bank_q][wr_addr] <= wr_data;
      end
    end

    assign rd_data = mem[rd_bank_q][rd_addr];
  end

endmodule

// File: rtl/pe_sparse_agu.sv
// Sparse FC / outer-product address generator. Walks the index list and emits
// trip_cnt address beats per entry on a valid/ready stream.
module pe_sparse_agu #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned IDX_W      = pe_sparse_agu_pkg::IDX_W,
  parameter int unsigned IDX_DEPTH  = 256,
  parameter int unsigned IDX_ADDR_W = pe_sparse_agu_pkg::bw(IDX_DEPTH),
  parameter int unsigned BATCH      = pe_sparse_agu_pkg::BATCH,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  switch_idx_buf,
  input  logic [IDX_ADDR_W-1:0] idx_wr_addr,
  input  logic [2*IDX_W-1:0]    idx_wr_data,
  input  logic                  idx_wr_en,
  input  logic                  start,
  input  logic                  mode,
  input  logic [CNT_W-1:0]      idx_cnt,
  input  logic [CNT_W-1:0]      trip_cnt,
  input  logic [ADDR_W-1:0]     stride,
  input  logic                  is_new,
  input  logic [BATCH-1:0]      lane_mask,
  output logic                  done,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_W-1:0]     dbuf_addr,
  output logic [ADDR_W-1:0]     pbuf_addr,
  output logic [ADDR_W-1:0]     abuf_addr,
  output logic [BATCH-1:0]      abuf_acc_en,
  output logic                  abuf_acc_new,
  output logic                  mac_new_acc
);

  import pe_sparse_agu_pkg::*;

  localparam logic [CNT_W-1:0] CntOne = 1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } state_e;

  state_e             state_q;
  agu_mode_e          mode_q;
  logic [CNT_W-1:0]   idx_cnt_q;
  logic [CNT_W-1:0]   trip_cnt_q;
  logic [ADDR_W-1:0]  stride_q;
  logic               is_new_q;
  logic [CNT_W-1:0]   i_q;
  logic [CNT_W-1:0]   t_q;
  logic [ADDR_W-1:0]  off_q;
  logic [IDX_W-1:0]   key_q;

  logic [2*IDX_W-1:0] rd_data;
  logic [IDX_W-1:0]   p_idx;
  logic [IDX_W-1:0]   d_idx;
  logic [IDX_W-1:0]   key;
  logic [ADDR_W-1:0]  d_base;
  logic [ADDR_W-1:0]  a_base;
  logic               load;
  logic               last_trip;
  logic               last_entry;
  logic               acc_new;

  ping_pong_ram #(
    .DEPTH    (IDX_DEPTH),
    .WIDTH    (2 * IDX_W),
    .ADDR_W   (IDX_ADDR_W),
    .RAM_TYPE ("distributed")
  ) u_idx_ram (
    .clk        (clk),
    .rst        (rst),
    .switch_buf (switch_idx_buf),
    .wr_addr    (idx_wr_addr),
    .wr_data    (idx_wr_data),
    .wr_en      (idx_wr_en),
    .rd_addr    (IDX_ADDR_W'(i_q)),
    .rd_data    (rd_data)
  );

  // Decode the current entry and the beat that would be loaded this cycle.
  always_comb begin
    p_idx      = rd_data[2*IDX_W-1:IDX_W];
    d_idx      = rd_data[IDX_W-1:0];
    key        = (mode_q == AGU_FWD) ? p_idx : d_idx;
    d_base     = (mode_q == AGU_FWD) ? ADDR_W'(d_idx) : ADDR_W'(p_idx);
    a_base     = (mode_q == AGU_FWD) ? ADDR_W'(p_idx) : ADDR_W'(d_idx);
    load       = (state_q == StRun) && (!out_valid || out_ready);
    last_trip  = (t_q == trip_cnt_q - CntOne);
    last_entry = (i_q == idx_cnt_q - CntOne);
    // A new run starts whenever the accumulation key changes between entries.
    acc_new    = is_new_q && ((i_q == '0) || (key != key_q));
  end

  // Walk FSM with counters and the registered output beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      mode_q       <= AGU_FWD;
      idx_cnt_q    <= '0;
      trip_cnt_q   <= '0;
      stride_q     <= '0;
      is_new_q     <= 1'b0;
      i_q          <= '0;
      t_q          <= '0;
      off_q        <= '0;
      key_q        <= '0;
      done         <= 1'b1;
      out_valid    <= 1'b0;
      dbuf_addr    <= '0;
      pbuf_addr    <= '0;
      abuf_addr    <= '0;
      abuf_acc_en  <= '0;
      abuf_acc_new <= 1'b0;
      mac_new_acc  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          done <= 1'b1;
          if (start) begin
            mode_q      <= agu_mode_e'(mode);
            idx_cnt_q   <= idx_cnt;
            trip_cnt_q  <= trip_cnt;
            stride_q    <= stride;
            is_new_q    <= is_new;
            abuf_acc_en <= lane_mask;
            i_q         <= '0;
            t_q         <= '0;
            off_q       <= '0;
            key_q       <= '0;
            done        <= 1'b0;
            // An empty walk only pulses done low for one cycle.
            if ((idx_cnt != '0) && (trip_cnt != '0)) begin
              state_q <= StRun;
            end
          end
        end
        StRun: begin
          if (load) begin
            out_valid    <= 1'b1;
            dbuf_addr    <= d_base + off_q;
            abuf_addr    <= a_base + off_q;
            pbuf_addr    <= ADDR_W'(i_q);
            abuf_acc_new <= acc_new;
            mac_new_acc  <= (t_q == '0);
            if (last_trip) begin
              t_q   <= '0;
              off_q <= '0;
              i_q   <= i_q + CntOne;
              key_q <= key;
              if (last_entry) begin
                state_q <= StDrain;
              end
            end else begin
              t_q   <= t_q + CntOne;
              off_q <= off_q + stride_q;
            end
          end
        end
        StDrain: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            done      <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_sparse_agu.sv
// Scoreboard bench for pe_sparse_agu: directed walks push hand-computed beats,
// a negedge monitor pops and compares on every handshake.
module tb_pe_sparse_agu;

  logic        clk = 1'b0;
  logic        rst;
  logic        switch_idx_buf;
  logic [7:0]  idx_wr_addr;
  logic [15:0] idx_wr_data;
  logic        idx_wr_en;
  logic        start;
  logic        mode;
  logic [7:0]  idx_cnt;
  logic [7:0]  trip_cnt;
  logic [7:0]  stride;
  logic        is_new;
  logic [3:0]  lane_mask;
  logic        done;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  dbuf_addr;
  logic [7:0]  pbuf_addr;
  logic [7:0]  abuf_addr;
  logic [3:0]  abuf_acc_en;
  logic        abuf_acc_new;
  logic        mac_new_acc;

  pe_sparse_agu #(
    .ADDR_W     (8),
    .IDX_W      (8),
    .IDX_DEPTH  (256),
    .IDX_ADDR_W (8),
    .BATCH      (4),
    .CNT_W      (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .switch_idx_buf (switch_idx_buf),
    .idx_wr_addr    (idx_wr_addr),
    .idx_wr_data    (idx_wr_data),
    .idx_wr_en      (idx_wr_en),
    .start          (start),
    .mode           (mode),
    .idx_cnt        (idx_cnt),
    .trip_cnt       (trip_cnt),
    .stride         (stride),
    .is_new         (is_new),
    .lane_mask      (lane_mask),
    .done           (done),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .dbuf_addr      (dbuf_addr),
    .pbuf_addr      (pbuf_addr),
    .abuf_addr      (abuf_addr),
    .abuf_acc_en    (abuf_acc_en),
    .abuf_acc_new   (abuf_acc_new),
    .mac_new_acc    (mac_new_acc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] dbuf;
    logic [7:0] pbuf;
    logic [7:0] abuf;
    logic [3:0] en;
    logic       acc_new;
    logic       mac;
  } beat_t;

  beat_t sb[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    beats_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int d, input int p, input int a, input logic [3:0] en,
                      input logic nw, input logic mac);
    beat_t b;
    b.dbuf = 8'(d);
    b.pbuf = 8'(p);
    b.abuf = 8'(a);
    b.en = en;
    b.acc_new = nw;
    b.mac = mac;
    sb.push_back(b);
  endtask

  // Monitor: compares each accepted beat and checks holding while stalled.
  initial begin
    beat_t e;
    beat_t prev;
    bit    stalled;
    stalled = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0;
      end else begin
        if (out_valid && stalled) begin
          check("stall_dbuf", dbuf_addr, prev.dbuf);
          check("stall_abuf", abuf_addr, prev.abuf);
          check("stall_pbuf", pbuf_addr, prev.pbuf);
        end
        if (out_valid && out_ready) begin
          beats_seen++;
          if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_beat: got dbuf %0d, expected no beat", dbuf_addr);
          end else begin
            e = sb.pop_front();
            check("dbuf_addr", dbuf_addr, e.dbuf);
            check("pbuf_addr", pbuf_addr, e.pbuf);
            check("abuf_addr", abuf_addr, e.abuf);
            check("abuf_acc_en", abuf_acc_en, e.en);
            check("abuf_acc_new", abuf_acc_new, e.acc_new);
            check("mac_new_acc", mac_new_acc, e.mac);
          end
        end
        stalled = out_valid && !out_ready;
        prev.dbuf = dbuf_addr;
        prev.abuf = abuf_addr;
        prev.pbuf = pbuf_addr;
      end
    end
  end

  task automatic wr(input int a, input int p, input int d);
    @(posedge clk); #1;
    idx_wr_addr = 8'(a);
    idx_wr_data = {8'(p), 8'(d)};
    idx_wr_en = 1'b1;
    @(posedge clk); #1;
    idx_wr_en = 1'b0;
  endtask

  task automatic swap();
    @(posedge clk); #1;
    switch_idx_buf = 1'b1;
    @(posedge clk); #1;
    switch_idx_buf = 1'b0;
  endtask

  task automatic do_start(input logic m, input int ic, input int tc, input int st,
                          input logic nw, input logic [3:0] mk);
    @(posedge clk); #1;
    mode = m;
    idx_cnt = 8'(ic);
    trip_cnt = 8'(tc);
    stride = 8'(st);
    is_new = nw;
    lane_mask = mk;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Wait until idle with an empty scoreboard; optional 1,0,0,1 ready pattern.
  task automatic wait_idle(input string name, input bit tog);
    logic [3:0] pat;
    int k;
    pat = 4'b1001;
    k = 0;
    while (!(done && sb.size() == 0) && k < 300) begin
      if (tog) out_ready = pat[3 - (k % 4)];
      @(posedge clk); #1;
      k++;
    end
    out_ready = 1'b1;
    if (k >= 300) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: got %0d beats pending, expected 0", name, sb.size());
    end
  endtask

  task automatic push_fwd_list(input logic [3:0] mk, input bit nw);
    push(5, 0, 1, mk, nw, 1'b1);
    push(21, 0, 17, mk, nw, 1'b0);
    push(7, 1, 1, mk, 1'b0, 1'b1);
    push(23, 1, 17, mk, 1'b0, 1'b0);
    push(9, 2, 2, mk, nw, 1'b1);
    push(25, 2, 18, mk, nw, 1'b0);
  endtask

  initial begin
    int b0;
    rst = 1'b1;
    switch_idx_buf = 1'b0;
    idx_wr_addr = '0;
    idx_wr_data = '0;
    idx_wr_en = 1'b0;
    start = 1'b0;
    mode = 1'b0;
    idx_cnt = '0;
    trip_cnt = '0;
    stride = '0;
    is_new = 1'b0;
    lane_mask = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_done", done, 1);
    check("rst_valid", out_valid, 0);
    check("rst_dbuf", dbuf_addr, 0);
    check("rst_acc_en", abuf_acc_en, 0);
    rst = 1'b0;

    // Entries {p,d}: {1,5},{1,7},{2,9}, written to the idle bank then swapped in.
    wr(0, 1, 5);
    wr(1, 1, 7);
    wr(2, 2, 9);
    swap();

    // 1: FWD, no run clearing.
    b0 = beats_seen;
    push_fwd_list(4'b1011, 1'b0);
    do_start(1'b0, 3, 2, 16, 1'b0, 4'b1011);
    check("t1_done_low", done, 0);
    wait_idle("t1", 1'b0);
    check("t1_beats", beats_seen - b0, 6);

    // 2: is_new marks the first and third entries (key 1,1,2).
    b0 = beats_seen;
    push_fwd_list(4'b0110, 1'b1);
    do_start(1'b0, 3, 2, 16, 1'b1, 4'b0110);
    wait_idle("t2", 1'b0);
    check("t2_beats", beats_seen - b0, 6);

    // 3: BWD role swap, then BWD with is_new (keys 5,7,9 all distinct).
    b0 = beats_seen;
    push(1, 0, 5, 4'hf, 1'b0, 1'b1);
    push(17, 0, 21, 4'hf, 1'b0, 1'b0);
    push(1, 1, 7, 4'hf, 1'b0, 1'b1);
    push(17, 1, 23, 4'hf, 1'b0, 1'b0);
    push(2, 2, 9, 4'hf, 1'b0, 1'b1);
    push(18, 2, 25, 4'hf, 1'b0, 1'b0);
    do_start(1'b1, 3, 2, 16, 1'b0, 4'hf);
    wait_idle("t3", 1'b0);
    push(1, 0, 5, 4'h1, 1'b1, 1'b1);
    push(17, 0, 21, 4'h1, 1'b1, 1'b0);
    push(1, 1, 7, 4'h1, 1'b1, 1'b1);
    push(17, 1, 23, 4'h1, 1'b1, 1'b0);
    push(2, 2, 9, 4'h1, 1'b1, 1'b1);
    push(18, 2, 25, 4'h1, 1'b1, 1'b0);
    do_start(1'b1, 3, 2, 16, 1'b1, 4'h1);
    wait_idle("t3b", 1'b0);
    check("t3_beats", beats_seen - b0, 12);

    // 4: backpressure with ready pattern 1,0,0,1.
    b0 = beats_seen;
    push_fwd_list(4'b1011, 1'b0);
    do_start(1'b0, 3, 2, 16, 1'b0, 4'b1011);
    wait_idle("t4", 1'b1);
    check("t4_beats", beats_seen - b0, 6);

    // 5: empty walks pulse done low for one cycle and emit nothing.
    b0 = beats_seen;
    do_start(1'b0, 0, 2, 16, 1'b0, 4'hf);
    check("t5_done_pulse", done, 0);
    @(posedge clk); #1;
    check("t5_done_back", done, 1);
    do_start(1'b0, 3, 0, 16, 1'b0, 4'hf);
    check("t5_trip0_pulse", done, 0);
    @(posedge clk); #1;
    check("t5_trip0_back", done, 1);
    repeat (3) @(posedge clk);
    #1;
    check("t5_no_valid", out_valid, 0);
    check("t5_beats", beats_seen - b0, 0);

    // 5b: start while busy is ignored; writes to the idle bank leave the walk intact.
    b0 = beats_seen;
    push_fwd_list(4'b1011, 1'b0);
    do_start(1'b0, 3, 2, 16, 1'b0, 4'b1011);
    wr(0, 99, 99);
    do_start(1'b1, 5, 3, 7, 1'b1, 4'h0);
    wait_idle("t5b", 1'b0);
    check("t5b_beats", beats_seen - b0, 6);

    // 6: asynchronous reset mid-walk drops the beat in flight.
    push_fwd_list(4'b1011, 1'b0);
    do_start(1'b0, 3, 2, 16, 1'b0, 4'b1011);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    sb.delete();
    #1;
    check("t6_done", done, 1);
    check("t6_valid", out_valid, 0);
    check("t6_dbuf", dbuf_addr, 0);
    check("t6_abuf", abuf_addr, 0);
    check("t6_pbuf", pbuf_addr, 0);
    check("t6_acc_en", abuf_acc_en, 0);
    check("t6_mac", mac_new_acc, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Bank select is back at 0 after reset: load a fresh list and swap it in.
    wr(0, 1, 5);
    wr(1, 200, 60);
    swap();
    b0 = beats_seen;
    // stride 200, 3 trips: offsets 0,200,144 (mod 256).
    push(5, 0, 1, 4'b0101, 1'b1, 1'b1);
    push(205, 0, 201, 4'b0101, 1'b1, 1'b0);
    push(149, 0, 145, 4'b0101, 1'b1, 1'b0);
    push(60, 1, 200, 4'b0101, 1'b1, 1'b1);
    push(4, 1, 144, 4'b0101, 1'b1, 1'b0);
    push(204, 1, 88, 4'b0101, 1'b1, 1'b0);
    do_start(1'b0, 2, 3, 200, 1'b1, 4'b0101);
    wait_idle("t6_wrap", 1'b0);
    check("t6_beats", beats_seen - b0, 6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
